// File: rtl/rsa_pkg.sv
// Shared constants for the RSA operand path (loader, mon_exp, operand BRAM).
// Default geometry, derived beat/word counts, loader states and address map.
package rsa_pkg;

    localparam int DEF_BITLEN    = 1024;
    localparam int DEF_DBITS     = 512;
    localparam int DEF_ABITS     = 8;
    localparam int DEF_IN_W      = 32;
    localparam int DEF_NUM_OPS   = 2;
    localparam int DEF_BASE_ADDR = 0;

    localparam int BPW         = DEF_DBITS / DEF_IN_W;
    localparam int WPO         = DEF_BITLEN / DEF_DBITS;
    localparam int TOTAL_BEATS = BPW * WPO * DEF_NUM_OPS;

    // Operand k occupies WPO consecutive words starting at BASE_ADDR + k*WPO.
    localparam int OP_STRIDE = WPO;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_FLUSH = 2'd1,
        S_RUN   = 2'd2
    } loader_state_e;

    function automatic int operand_word_addr(input int base, input int stride,
                                             input int k, input int h);
        return base + stride * k + h;
    endfunction

endpackage

// File: rtl/word_packer.sv
// Packs narrow beats into one wide word, little-endian: the first beat of a
// word ends up in the least significant IN_W bits.
module word_packer
#(
    parameter int DBITS = 512,
    parameter int IN_W  = 32
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             beat_valid,
    input  logic [IN_W-1:0]  beat_data,
    output logic             beat_last,
    output logic             word_valid,
    output logic [DBITS-1:0] word
);

    localparam int BEATS = DBITS / IN_W;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [DBITS-1:0] sr_q;
    logic [DBITS-1:0] sr_d;
    logic [CW-1:0]    cnt_q;
    logic [DBITS-1:0] word_q;
    logic             word_valid_q;

    // New beat enters at the MSBs; everything already held moves down one beat.
    assign sr_d      = DBITS'({beat_data, sr_q} >> IN_W);
    assign beat_last = (cnt_q == CW'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q         <= '0;
            cnt_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            if (beat_valid) begin
                sr_q <= sr_d;
                if (beat_last) begin
                    cnt_q        <= '0;
                    word_q       <= sr_d;
                    word_valid_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign word       = word_q;
    assign word_valid = word_valid_q;

endmodule

// File: rtl/rsa_operand_loader.sv
// Streams operands A and B from the host into the operand BRAM, then holds
// mon_exp start until it reports stop and re-arms for the next load.
module rsa_operand_loader
    import rsa_pkg::*;
#(
    parameter int BITLEN    = DEF_BITLEN,
    parameter int DBITS     = DEF_DBITS,
    parameter int ABITS     = DEF_ABITS,
    parameter int IN_W      = DEF_IN_W,
    parameter int NUM_OPS   = DEF_NUM_OPS,
    parameter int BASE_ADDR = DEF_BASE_ADDR
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic [ABITS-1:0] wr_addr,
    output logic [DBITS-1:0] wr_data,
    output logic             wr_en,
    output logic             start,
    input  logic             stop,
    output logic             busy
);

    localparam int WORDS_PER_OP = BITLEN / DBITS;
    localparam int NUM_WORDS    = WORDS_PER_OP * NUM_OPS;
    localparam int WCW          = $clog2(NUM_WORDS + 1);

    loader_state_e    state_q;
    logic [WCW-1:0]   word_cnt_q;
    logic [ABITS-1:0] wr_addr_q;
    logic             start_q;
    logic             accept;
    logic             beat_last;

    // Gated by rst so no beat can be taken while the loader is being reset.
    assign in_ready = (state_q == S_LOAD) && !rst;
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != S_LOAD);

    word_packer #(
        .DBITS (DBITS),
        .IN_W  (IN_W)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .beat_valid (accept),
        .beat_data  (in_data),
        .beat_last  (beat_last),
        .word_valid (wr_en),
        .word       (wr_data)
    );

    // Word index k*WPO+h maps straight onto BASE_ADDR + k*WPO + h.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LOAD;
            word_cnt_q <= '0;
            wr_addr_q  <= '0;
            start_q    <= 1'b0;
        end else begin
            unique case (state_q)
                S_LOAD: begin
                    if (accept && beat_last) begin
                        wr_addr_q  <= ABITS'(BASE_ADDR) + ABITS'(word_cnt_q);
                        word_cnt_q <= word_cnt_q + 1'b1;
                        if (word_cnt_q == WCW'(NUM_WORDS - 1)) begin
                            state_q <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    state_q <= S_RUN;
                    start_q <= 1'b1;
                end
                S_RUN: begin
                    if (stop) begin
                        state_q    <= S_LOAD;
                        start_q    <= 1'b0;
                        word_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q    <= S_LOAD;
                    start_q    <= 1'b0;
                    word_cnt_q <= '0;
                end
            endcase
        end
    end

    assign wr_addr = wr_addr_q;
    assign start   = start_q;

endmodule

// File: doc/rsa_operand_loader.md
Name: rsa_operand_loader

Overview:
Upstream feeder for mon_exp. Accepts operands A and B as a stream of narrow host beats and packs them into DBITS-wide words. Writes the packed words into the operand BRAM through its second write port (WR_ADDR2/WR_DATA2/WR_EN2). Once both operands are resident, it raises mon_exp start and holds it until mon_exp reports stop, then re-arms for the next load.

Parameters:
BITLEN, 1024, operand width in bits
DBITS, 512, BRAM word width
ABITS, 8, BRAM address width
IN_W, 32, host beat width; DBITS must be a multiple of IN_W
NUM_OPS, 2, operands per load (A, B)
BASE_ADDR, 0, BRAM address of operand A low word

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  host beat valid
in_ready  out  1  loader accepts beat this cycle
in_data  in  IN_W  host beat
wr_addr  out  ABITS  to bram WR_ADDR2
wr_data  out  DBITS  to bram WR_DATA2
wr_en  out  1  to bram WR_EN2
start  out  1  to mon_exp start (level)
stop  in  1  from mon_exp stop
busy  out  1  high whenever the state is not LOAD

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Derived constants: BPW = DBITS/IN_W (16). WPO = BITLEN/DBITS (2). TOTAL_BEATS = BPW*WPO*NUM_OPS (64).
- Handshake: a beat transfers when in_valid && in_ready on a rising clk. in_valid while in_ready=0 is ignored; the host holds the beat.
- Ordering is little-endian throughout:
  - Beat j of a BRAM word lands at bits [IN_W*j +: IN_W].
  - Operand k, word h (h=0 is the low word) is written to BASE_ADDR + WPO*k + h.
  - Default map: A low=0, A high=1, B low=2, B high=3.
- Packing: shift register; each accepted beat shifts right by IN_W and enters at the MSBs. After BPW beats, the first beat sits at the LSBs.
- Write timing:
  - The write is registered. On the cycle after the BPW-th beat of a word is accepted, wr_en=1 for exactly one cycle, with wr_addr and wr_data valid.
  - Beat acceptance continues in that same cycle. No bubble is required between words.
- States:
  - LOAD: in_ready=1. Beat counter and word counter advance on accept. Accepting beat TOTAL_BEATS-1 → FLUSH.
  - FLUSH: in_ready=0; the final word write occurs (wr_en=1) → RUN.
  - RUN: start=1, in_ready=0. Sample stop; on stop=1 → LOAD. start is 0 from the next cycle; in_ready=1 that same next cycle.
- stop while in LOAD or FLUSH is ignored. start is registered, so a stop already high on the first RUN cycle ends RUN after one cycle.
- Counters clear on entry to LOAD. There is no wrap within a load; the address is computed from the word counter, never modulo.
- Reset values:
  - start=0, wr_en=0, wr_addr=0, wr_data=0, busy=0.
  - in_ready=0 during the reset cycle; state enters LOAD, so in_ready=1 on the first cycle after rst deasserts.
- Reset mid-operation (any state): partial beats are discarded, no further wr_en, start drops the following cycle, and the loader returns to LOAD.
- Per load, exactly TOTAL_BEATS/BPW writes occur, in ascending address order.

Decomposition:
- Shared package/include (rsa_pkg):
  - BITLEN, DBITS, ABITS, IN_W.
  - Derived BPW, WPO, TOTAL_BEATS.
  - State encodings LOAD/FLUSH/RUN.
  - Address map constants (BASE_ADDR, operand stride WPO).
  - These are shared with mon_exp and bram instantiation.
- One sub-module, word_packer:
  - Holds the IN_W→DBITS shift register and beat counter.
  - Emits word_valid plus a registered word.
  - rsa_operand_loader keeps the FSM, address generation and start/stop handshake.

Test Plan:
- Reset: assert rst 3 cycles with in_valid=1 → start, wr_en, busy, in_ready=0; in_ready=1 on the first cycle after release.
- Basic load: stream A=435, B=571 (64 beats, in_valid always 1) → writes addr0=435, addr1=0, addr2=571, addr3=0, one wr_en cycle each. start=1 the cycle after the addr3 write, busy=1.
- Beat ordering and backpressure: beat i = i+1 with in_valid pseudo-random 50% → addr0 word field [32i +: 32] = i+1 for i=0..15; addr1..3 follow likewise; no beat lost or duplicated.
- Stop handshake: in RUN, assert stop 20 cycles after start → start=0 and in_ready=1 the next cycle. A second load of A=7, B=9 overwrites addr0=7, addr2=9.
- Reset mid-load: rst after 20 beats → no wr_en for the rest of that load. A fresh 64-beat load with A=1 writes addr0=1 first; 4 writes total.
- Stray stop: pulse stop during LOAD → ignored, no state change, start stays 0, load completes normally.
